// File: rtl/cmp_seq_pkg.sv
// Shared types and sizing helpers for the sequential pairwise comparator.
// No logic of its own; no latency or backpressure.
package cmp_seq_pkg;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  typedef enum logic [1:0] {GT = 2'd0, EQ = 2'd1, LT = 2'd2} cmpRes_t;

  localparam int DEF_WIDTH = 8;
  localparam int NPAIR     = DEF_WIDTH / 2;
  localparam int PAIRW     = $clog2(NPAIR) + 1;

  function automatic int nPairOf(input int width);
    return width / 2;
  endfunction

  // pairs must reach NPAIR itself, hence one extra bit over the index width
  function automatic int pairWOf(input int width);
    return $clog2(width / 2) + 1;
  endfunction

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Request/result bundle between a requester and cmp_seq_ctrl.
// start is only honoured while the controller is idle; no queuing.
interface cmp_seq_ctrl_if
  import cmp_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int PW = pairWOf(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             agtb;
  logic             aeqb;
  logic             altb;
  logic [PW-1:0]    pairs;

  modport master (
    output start, a, b,
    input  busy, done, agtb, aeqb, altb, pairs
  );

  modport slave (
    input  start, a, b,
    output busy, done, agtb, aeqb, altb, pairs
  );

endinterface

// File: rtl/cmp_seq_ctrl_slice.sv
// Combinational 2-bit unsigned magnitude comparator; exactly one output high.
// Zero latency, no backpressure.
module cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Walks one 2-bit slice over WIDTH-bit operands MSB pair first; done after n+1 edges (n = pairs examined).
// start is ignored while busy or done; the requester must wait for idle.
module cmp_seq_ctrl
  import cmp_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic           clk,
  input logic           rst,
  cmp_seq_ctrl_if.slave bus
);

  localparam int NP   = nPairOf(WIDTH);
  localparam int PW   = pairWOf(WIDTH);
  localparam int IDXW = (NP > 1) ? $clog2(NP) : 1;

  state_t           state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [IDXW-1:0]  idx;
  logic [PW-1:0]    pairCnt;
  logic             busyReg;
  logic             doneReg;
  logic             agtbReg;
  logic             aeqbReg;
  logic             altbReg;

  logic [1:0] pairA;
  logic [1:0] pairB;
  logic       sliceGt;
  logic       sliceEq;
  logic       sliceLt;
  cmpRes_t    res;

  assign pairA = aReg[{idx, 1'b0} +: 2];
  assign pairB = bReg[{idx, 1'b0} +: 2];

  cmp2_slice uSlice (
    .a  (pairA),
    .b  (pairB),
    .gt (sliceGt),
    .eq (sliceEq),
    .lt (sliceLt)
  );

  always_comb begin
    res = LT;
    case ({sliceGt, sliceEq, sliceLt})
      3'b100:  res = GT;
      3'b010:  res = EQ;
      default: res = LT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aReg    <= '0;
      bReg    <= '0;
      idx     <= '0;
      pairCnt <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      agtbReg <= 1'b0;
      aeqbReg <= 1'b0;
      altbReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            aReg    <= bus.a;
            bReg    <= bus.b;
            idx     <= IDXW'(NP - 1);
            pairCnt <= '0;
            agtbReg <= 1'b0;
            aeqbReg <= 1'b0;
            altbReg <= 1'b0;
            busyReg <= 1'b1;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          pairCnt <= pairCnt + PW'(1);
          // an equal pair only continues while lower pairs remain
          if (res == EQ && idx != '0) begin
            idx <= idx - IDXW'(1);
          end else begin
            agtbReg <= (res == GT);
            aeqbReg <= (res == EQ);
            altbReg <= (res == LT);
            busyReg <= 1'b0;
            doneReg <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          doneReg <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busyReg;
  assign bus.done  = doneReg;
  assign bus.agtb  = agtbReg;
  assign bus.aeqb  = aeqbReg;
  assign bus.altb  = altbReg;
  assign bus.pairs = pairCnt;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Randomised and directed scoreboard bench for cmp_seq_ctrl at WIDTH=8.
module tb_cmp_seq_ctrl;
  import cmp_seq_pkg::*;

  localparam int W  = 8;
  localparam int NP = W / 2;

  typedef struct {
    logic [2:0] fl;     // {agtb, aeqb, altb}
    int         pairs;
    int         e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmp_seq_ctrl_if #(.WIDTH(W)) bus ();

  cmp_seq_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t       sbq[$];
  int         nVec = 0;
  int         nFail = 0;
  int         cyc = 0;
  int         busyRun = 0;
  bit         seenDone = 1'b0;
  logic [2:0] lastFl = 3'b000;
  int         lastPairs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Reference: result from plain magnitude compare; pairs from the highest differing bit.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W-1:0] d;
    d = x ^ y;
    e.pairs = NP;
    for (int i = 0; i < W; i++)
      if (d[i]) e.pairs = NP - i / 2;
    e.fl = (x > y) ? 3'b100 : ((x == y) ? 3'b010 : 3'b001);
    e.e0 = 0;
    return e;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic rAtEdge;
    exp_t e;
    rAtEdge = rst;
    cyc++;
    #1;
    if (rAtEdge) begin
      busyRun  = 0;
      seenDone = 1'b0;
    end else begin
      if (bus.busy) begin
        busyRun++;
        chk("flags_clear_while_busy", {bus.agtb, bus.aeqb, bus.altb}, 0);
        chk("pairs_progress", bus.pairs, busyRun - 1);
        chk("done_while_busy", bus.done, 0);
      end
      if (bus.done) begin
        if (sbq.size() == 0) begin
          nVec++;
          nFail++;
          $display("FAIL spurious_done: got done=1 expected no pending result at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("result_flags", {bus.agtb, bus.aeqb, bus.altb}, e.fl);
          chk("result_pairs", bus.pairs, e.pairs);
          chk("done_latency", cyc - e.e0, e.pairs);
          chk("busy_cycles", busyRun, e.pairs);
          lastFl    = e.fl;
          lastPairs = e.pairs;
        end
        busyRun  = 0;
        seenDone = 1'b1;
      end else if (seenDone && !bus.busy) begin
        chk("one_hot", $countones({bus.agtb, bus.aeqb, bus.altb}), 1);
        chk("flags_hold", {bus.agtb, bus.aeqb, bus.altb}, lastFl);
        chk("pairs_hold", bus.pairs, lastPairs);
      end
    end
  end

  // Issue one start from IDLE; operands are scrambled right after capture.
  task automatic startCmp(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    exp_t e;
    @(negedge clk);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    if (push) begin
      e    = model(x, y);
      e.e0 = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  task automatic waitDone(input string nm);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < NP + 4) begin
      @(negedge clk);
      k++;
    end
    chk(nm, bus.done, 1);
  endtask

  task automatic chkAllZero(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_flags"}, {bus.agtb, bus.aeqb, bus.altb}, 0);
    chk({nm, "_pairs"}, bus.pairs, 0);
  endtask

  initial begin
    exp_t         e;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] flip;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chkAllZero("reset");
    rst = 1'b0;

    startCmp(8'hA5, 8'h65, 1'b1); waitDone("done_a5_65");
    startCmp(8'h3C, 8'h3C, 1'b1); waitDone("done_3c_3c");
    startCmp(8'h12, 8'h13, 1'b1); waitDone("done_12_13");

    // start held high; operands change after capture
    @(negedge clk);
    bus.a = 8'h40; bus.b = 8'h80; bus.start = 1'b1;
    @(posedge clk); #2;
    e = model(8'h40, 8'h80); e.e0 = cyc; sbq.push_back(e);
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'h00;
    waitDone("done_hold_first");
    @(negedge clk);
    chk("idle_after_done", bus.busy, 0);
    @(posedge clk); #2;
    e = model(8'hFF, 8'h00); e.e0 = cyc; sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("done_hold_second");

    // reset during the second COMPARE cycle aborts without a done pulse
    startCmp(8'h3C, 8'h3C, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chkAllZero("abort");
    repeat (6) begin
      @(negedge clk);
      chk("no_done_after_abort", bus.done, 0);
    end
    startCmp(8'h01, 8'h00, 1'b1); waitDone("done_01_00");

    startCmp(8'hFF, 8'hFE, 1'b1); waitDone("done_ff_fe");
    startCmp(8'h00, 8'h00, 1'b1); waitDone("done_00_00");

    for (int n = 0; n < 40; n++) begin
      x = W'($urandom);
      case ($urandom_range(0, 2))
        0: y = x;
        1: begin
          flip = W'($urandom_range(1, 3));
          y = x ^ (flip << (2 * $urandom_range(0, NP - 1)));
        end
        default: y = W'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      startCmp(x, y, 1'b1);
      waitDone("done_random");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "timeout");
  end

endmodule
